// File: rtl/rll_pkg.sv
// Shared types and defaults for the RLL transmit path.
package rll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    FLUSH
  } tx_state_e;

  localparam int unsigned    RLL_DATA_W    = 8;
  localparam logic [7:0]     RLL_PREAMBLE  = 8'hAA;
  localparam int unsigned    RLL_FLUSH_LEN = 4;
  localparam int unsigned    FRAME_CNT_W   = 16;

endpackage

// File: rtl/rll_bit_tick.sv
// Bit-period divider: tick_o is high on the last clock of each DIV-clock period.
module rll_bit_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned  CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/rll_tx_sequencer.sv
// Frame sequencer for the RLL encoder: preamble, MSB-first payload, zero flush.
module rll_tx_sequencer
  import rll_pkg::*;
#(
  parameter int unsigned          DATA_W      = RLL_DATA_W,
  parameter int unsigned          PRE_LEN     = 8,
  parameter logic [DATA_W-1:0]    PRE_PATTERN = DATA_W'(RLL_PREAMBLE),
  parameter int unsigned          FLUSH_LEN   = RLL_FLUSH_LEN,
  parameter int unsigned          DIV         = 1
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [DATA_W-1:0]      s_data_i,
  input  logic                   s_valid_i,
  input  logic                   s_last_i,
  output logic                   s_ready_o,
  output logic                   enc_data_o,
  output logic                   enc_strobe_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [FRAME_CNT_W-1:0] frame_bits_o
);

  localparam int unsigned     MAX_LEN    = (DATA_W > FLUSH_LEN) ? DATA_W : FLUSH_LEN;
  localparam int unsigned     IDX_W      = $clog2(MAX_LEN + 1);
  localparam logic [IDX_W-1:0] PRE_LAST   = IDX_W'(PRE_LEN - 1);
  localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] FLUSH_LAST = IDX_W'(FLUSH_LEN - 1);

  tx_state_e              state_q;
  logic [DATA_W-1:0]      sh_q;
  logic [DATA_W-1:0]      data_q;
  logic                   last_q;
  logic [IDX_W-1:0]       bit_idx_q;
  logic [FRAME_CNT_W-1:0] frame_bits_q;
  logic                   tick;
  logic                   busy;
  logic                   start;
  logic                   strobe;
  logic                   data_end;

  assign busy     = (state_q != IDLE);
  assign start    = (state_q == IDLE) & s_valid_i;
  assign strobe   = busy & tick;
  assign data_end = (state_q == DATA) & tick & (bit_idx_q == DATA_LAST);

  rll_bit_tick #(.DIV(DIV)) u_tick (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .en_i   (busy),
    .clr_i  (start),
    .tick_o (tick)
  );

  // The shift register MSB is the serial line; it is zero-filled during flush and idle.
  assign enc_data_o   = sh_q[DATA_W-1];
  assign enc_strobe_o = strobe;
  assign busy_o       = busy;
  assign s_ready_o    = (state_q == IDLE) | data_end;
  assign done_o       = (state_q == FLUSH) & tick & (bit_idx_q == FLUSH_LAST);
  assign err_o        = data_end & ~last_q & ~s_valid_i;
  assign frame_bits_o = frame_bits_q;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      bit_idx_q    <= '0;
      frame_bits_q <= '0;
    end else begin
      if (strobe && (frame_bits_q != '1)) begin
        frame_bits_q <= frame_bits_q + FRAME_CNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (s_valid_i) begin
            data_q       <= s_data_i;
            last_q       <= s_last_i;
            sh_q         <= PRE_PATTERN;
            bit_idx_q    <= '0;
            frame_bits_q <= '0;
            state_q      <= PREAMBLE;
          end
        end
        PREAMBLE: begin
          if (tick) begin
            if (bit_idx_q == PRE_LAST) begin
              sh_q      <= data_q;
              bit_idx_q <= '0;
              state_q   <= DATA;
            end else begin
              sh_q      <= {sh_q[DATA_W-2:0], 1'b0};
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx_q == DATA_LAST) begin
              bit_idx_q <= '0;
              if (!last_q && s_valid_i) begin
                sh_q   <= s_data_i;
                last_q <= s_last_i;
              end else begin
                sh_q    <= '0;
                state_q <= FLUSH;
              end
            end else begin
              sh_q      <= {sh_q[DATA_W-2:0], 1'b0};
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
        end
        FLUSH: begin
          if (tick) begin
            sh_q <= '0;
            if (bit_idx_q == FLUSH_LAST) begin
              bit_idx_q <= '0;
              state_q   <= IDLE;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
